dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory (dmem) between the processor (port 0) and a secondary requester such as a debug loader or DMA engine (port 1). It sits between the requesters and the dmem address/data/wren/q pins and sequences one memory access at a time. It serialises accesses through a small state machine and returns read data with fixed latency.

## Interface
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, dmem data width

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- p0_req / p1_req  in  1  access request; held until granted
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_wren / p1_wren  in  1  1 = write, 0 = read
- p0_gnt / p1_gnt  out  1  one-cycle pulse: request captured this edge
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse: read data valid
- p0_rdata / p1_rdata  out  DATA_W  read data, meaningful only with rvalid
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem wren
- mem_q  in  DATA_W  from dmem q
- busy  out  1  high in ACCESS or RESP

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, pick winner, assert its gnt combinationally, capture addr/wdata/wren/port id on edge, go ACCESS; else stay.
- ACCESS: drive mem_address/mem_data from capture; mem_wren = captured wren; go RESP.
- RESP: if captured op was read, assert rvalid of captured port, rdata = mem_q. Same cycle, arbitrate as in IDLE: on a winner, assert gnt and go ACCESS; else go IDLE.
- Non-granted port sees no gnt and must keep req/addr/wdata/wren stable.
- Requester may drop or change req in the cycle after its gnt.
- rdata of the non-responding port: 0. rvalid is never asserted for writes.
- mem_wren = 0 in every state except ACCESS. mem_address/mem_data hold last captured value outside ACCESS.
- Winner selection: see Configuration. Single requester always wins.

## Timing
- Reset values: state IDLE, all gnt/rvalid/mem_wren/busy = 0, mem_address = 0, mem_data = 0, rdata = 0, RR pointer = port 0 preferred.
- Read latency: gnt in cycle N, memory access in N+1, rvalid and rdata in N+2.
- Write: gnt in N, mem_wren = 1 in N+1 only.
- Sustained throughput: one access per 2 cycles. The RESP cycle of one access overlaps the gnt of the next.
- Reset in ACCESS: mem_wren forced 0 from the reset edge, so the write is not committed to dmem; captured access is discarded.
- Reset in RESP: no rvalid after reset; pending read is dropped.
- Reset asserted with req high: no gnt while reset is high; arbitration resumes in the first cycle after reset deasserts.
- Simultaneous req on both ports: exactly one gnt per arbitration cycle; never both.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. One-bit pointer names the preferred port and flips to the non-granted port after every grant. Under continuous dual requests, grants alternate p0, p1, p0, …
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins. No pointer register exists. Port 1 is served only in arbitration cycles where p0_req = 0.

## Test plan
- Single read: preload dmem[0x010] = 0xDEADBEEF. p0 read addr 0x010. Require p0_gnt in cycle N, mem_wren = 0, p0_rvalid in N+2 with p0_rdata = 0xDEADBEEF, and p1 outputs all 0.
- Write then read: p1 writes 0x12345678 to 0x0FF, then p1 reads 0x0FF. Require mem_wren high for exactly 1 cycle and p1_rdata = 0x12345678 on p1_rvalid.
- Dual contention, RR built: both ports hold reads to 0x001 and 0x002 for 8 cycles. Require gnt order p0, p1, p0, p1, one grant every 2 cycles, never both gnt in the same cycle.
- Dual contention, RR not built: same stimulus. Require p0_gnt on every arbitration cycle and p1_gnt never while p0_req = 1. After p0_req drops, require p1_gnt in the next arbitration cycle.
- Reset mid-write: assert reset in the ACCESS cycle of a p0 write of 0xAAAA5555 to 0x020. Require mem_wren = 0 from the reset edge, dmem[0x020] unchanged, all outputs at reset values, state IDLE.
- Back-to-back reads: p0 issues 4 reads to 0x000–0x003 preloaded 1, 2, 3, 4. Require rvalid on cycles N+2, N+4, N+6, N+8 with rdata 1, 2, 3, 4 and busy continuously high.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter serialising accesses to a single-port synchronous dmem
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_wren,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_wren,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic                arb_cycle;
  logic                grant;
  logic                win_port;
  logic                resp_read;
  logic                cap_port;
  logic                cap_wren;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_data;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    win_port = ~p0_req;
    if (p0_req && p1_req) win_port = rr_ptr;
  end

  // Pointer names the preferred port: the one that lost the last grant.
  always_ff @(posedge clock) begin
    if (reset) rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= ~win_port;
  end
`else
  always_comb begin
    win_port = ~p0_req;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cap_port <= 1'b0;
      cap_wren <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        cap_port <= win_port;
        cap_wren <= win_port ? p1_wren  : p0_wren;
        cap_addr <= win_port ? p1_addr  : p0_addr;
        cap_data <= win_port ? p1_wdata : p0_wdata;
      end
    end
  end

  // Strobes are masked by reset so an access in flight never reaches dmem or a requester.
  always_comb begin
    state_next = state;
    arb_cycle  = 1'b0;
    case (state)
      IDLE:    arb_cycle  = 1'b1;
      ACCESS:  state_next = RESP;
      RESP:    arb_cycle  = 1'b1;
      default: state_next = IDLE;
    endcase
    grant = arb_cycle && (p0_req || p1_req) && !reset;
    if (arb_cycle) state_next = grant ? ACCESS : IDLE;

    p0_gnt    = grant && !win_port;
    p1_gnt    = grant && win_port;
    resp_read = (state == RESP) && !cap_wren && !reset;
    p0_rvalid = resp_read && !cap_port;
    p1_rvalid = resp_read && cap_port;
    p0_rdata  = p0_rvalid ? mem_q : '0;
    p1_rdata  = p1_rvalid ? mem_q : '0;
    mem_wren  = (state == ACCESS) && cap_wren && !reset;
    busy      = (state != IDLE);
  end

  assign mem_address = cap_addr;
  assign mem_data    = cap_data;

endmodule
